// File: rtl/csr_test_sequencer.sv
// Avalon-MM initiator that runs one memory-checker test over its CSR slave.
// It writes the parameter words and the start bit, then polls the finish flag.
// When the test finishes it reads back the result words and pulses done_o.
// Ports:
//   clk_sys_i, rst_sys_i       : clock, synchronous active-low reset
//   run_i, param_i             : run request and parameter words (word k at [32k+:32])
//   busy_o, done_o, error_o    : status; error_o flags a read timeout and is sticky
//   poll_cnt_o, result_o       : finish polls issued this run, captured result words
//   read_o .. readdata_i       : Avalon-MM master port (slave has no waitrequest)
module csr_test_sequencer #(
  parameter int PARAM_CNT   = 3,
  parameter int PARAM_BASE  = 1,
  parameter int START_ADDR  = 0,
  parameter int FINISH_ADDR = 4,
  parameter int RESULT_BASE = 5,
  parameter int RESULT_CNT  = 3,
  parameter int POLL_GAP    = 4,
  parameter int RD_TIMEOUT  = 16
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_i,
  input  logic                    run_i,
  input  logic [PARAM_CNT*32-1:0] param_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [15:0]             poll_cnt_o,
  output logic [RESULT_CNT*32-1:0] result_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [3:0]              address_o,
  output logic [31:0]             writedata_o,
  input  logic                    readdatavalid_i,
  input  logic [31:0]             readdata_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PARAM,
    S_WR_START,
    S_POLL_RD,
    S_POLL_WAIT,
    S_GAP,
    S_RES_RD,
    S_RES_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0]  PB       = 4'(PARAM_BASE);
  localparam logic [3:0]  SA       = 4'(START_ADDR);
  localparam logic [3:0]  FA       = 4'(FINISH_ADDR);
  localparam logic [3:0]  RB       = 4'(RESULT_BASE);
  localparam logic [7:0]  P_LAST   = 8'(PARAM_CNT - 1);
  localparam logic [7:0]  R_LAST   = 8'(RESULT_CNT - 1);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

  state_t                  state;
  logic [PARAM_CNT*32-1:0] prm_q;
  logic [7:0]              idx;
  logic [7:0]              idx_n;
  // Gap length in S_GAP, read age in the wait states.
  logic [15:0]             cnt;

  assign idx_n = idx + 8'd1;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_i) begin
      state       <= S_IDLE;
      prm_q       <= '0;
      idx         <= '0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      poll_cnt_o  <= '0;
      result_o    <= '0;
      read_o      <= 1'b0;
      write_o     <= 1'b0;
      address_o   <= '0;
      writedata_o <= '0;
    end else begin
      // Bus strobes last one cycle; address/data idle at zero.
      read_o      <= 1'b0;
      write_o     <= 1'b0;
      address_o   <= '0;
      writedata_o <= '0;
      done_o      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run_i) begin
            state       <= S_WR_PARAM;
            prm_q       <= param_i;
            idx         <= '0;
            busy_o      <= 1'b1;
            error_o     <= 1'b0;
            poll_cnt_o  <= '0;
            result_o    <= '0;
            write_o     <= 1'b1;
            address_o   <= PB;
            writedata_o <= param_i[31:0];
          end
        end
        S_WR_PARAM: begin
          write_o <= 1'b1;
          if (idx == P_LAST) begin
            state       <= S_WR_START;
            address_o   <= SA;
            writedata_o <= 32'h1;
          end else begin
            idx         <= idx_n;
            address_o   <= PB + idx_n[3:0];
            writedata_o <= prm_q[32*idx_n +: 32];
          end
        end
        S_WR_START: begin
          state     <= S_POLL_RD;
          read_o    <= 1'b1;
          address_o <= FA;
        end
        S_POLL_RD: begin
          state <= S_POLL_WAIT;
          cnt   <= 16'd1;
          if (poll_cnt_o != 16'hFFFF)
            poll_cnt_o <= poll_cnt_o + 16'd1;
        end
        S_POLL_WAIT: begin
          if (readdatavalid_i) begin
            if (readdata_i[0]) begin
              state     <= S_RES_RD;
              idx       <= '0;
              read_o    <= 1'b1;
              address_o <= RB;
            end else begin
              state <= S_GAP;
              cnt   <= '0;
            end
          end else if (cnt == TMO_LAST) begin
            state   <= S_DONE;
            error_o <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= S_POLL_RD;
            read_o    <= 1'b1;
            address_o <= FA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RES_RD: begin
          state <= S_RES_WAIT;
          cnt   <= 16'd1;
        end
        S_RES_WAIT: begin
          if (readdatavalid_i) begin
            result_o[32*idx +: 32] <= readdata_i;
            if (idx == R_LAST) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state     <= S_RES_RD;
              idx       <= idx_n;
              read_o    <= 1'b1;
              address_o <= RB + idx_n[3:0];
            end
          end else if (cnt == TMO_LAST) begin
            state   <= S_DONE;
            error_o <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_test_sequencer.sv
// Self-checking bench for csr_test_sequencer.
// Drives runs against a one-cycle-latency CSR slave model and scoreboards bus cycles and done pulses.
module tb_csr_test_sequencer;

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    int          gap;
  } bus_t;

  typedef struct {
    bit          err;
    logic [15:0] pc;
    logic [95:0] res;
    int          gap;
  } done_t;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i;
  logic        run_i;
  logic [95:0] param_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] poll_cnt_o;
  logic [95:0] result_o;
  logic        read_o;
  logic        write_o;
  logic [3:0]  address_o;
  logic [31:0] writedata_o;
  logic        readdatavalid_i = 1'b0;
  logic [31:0] readdata_i = 32'h0;

  int n_chk = 0;
  int n_fail = 0;

  bus_t  bq[$];
  done_t dq[$];

  // slave model configuration (written by stimulus only)
  int          fin_at = 0;
  logic [31:0] sres[3];
  logic [3:0]  drop_a = 4'hF;
  int          mark_req = 0;
  int          stray_req = 0;

  // slave/monitor state (written by monitor only)
  int          cyc = 0;
  int          last_bus = 0;
  int          poll_num = 0;
  int          mark_ack = 0;
  int          stray_ack = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_d = 32'h0;
  bit          outst = 1'b0;

  csr_test_sequencer dut (
    .clk_sys_i       (clk_sys_i),
    .rst_sys_i       (rst_sys_i),
    .run_i           (run_i),
    .param_i         (param_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .poll_cnt_o      (poll_cnt_o),
    .result_o        (result_o),
    .read_o          (read_o),
    .write_o         (write_o),
    .address_o       (address_o),
    .writedata_o     (writedata_o),
    .readdatavalid_i (readdatavalid_i),
    .readdata_i      (readdata_i)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model and bus/done monitor, all on the falling edge.
  always @(negedge clk_sys_i) begin
    bus_t  b;
    done_t d;
    cyc++;
    readdatavalid_i = pend;
    readdata_i = pend ? pend_d : 32'h0;
    pend = 1'b0;
    if (stray_ack != stray_req) begin
      readdatavalid_i = 1'b1;
      readdata_i = 32'h1;
      stray_ack = stray_req;
    end
    if (readdatavalid_i || done_o || !rst_sys_i) outst = 1'b0;
    if (run_i && mark_ack != mark_req) begin
      last_bus = cyc;
      mark_ack = mark_req;
    end
    if (read_o || write_o) begin
      chk("rw_excl", 96'(read_o & write_o), 96'h0);
      if (read_o) begin
        chk("rd_outstanding", 96'(outst), 96'h0);
        outst = 1'b1;
        if (address_o == 4'd4) begin
          poll_num++;
          pend = 1'b1;
          pend_d = {31'h0, poll_num >= fin_at};
        end else if (address_o != drop_a) begin
          pend = 1'b1;
          if (address_o >= 4'd5 && address_o <= 4'd7)
            pend_d = sres[int'(address_o) - 5];
          else
            pend_d = 32'h0;
        end
      end
      if (bq.size() == 0) begin
        chk("extra_bus", 96'(address_o), 96'hF0);
      end else begin
        b = bq.pop_front();
        chk("bus_kind", 96'(write_o), 96'(b.wr));
        chk("bus_addr", 96'(address_o), 96'(b.a));
        if (b.wr) chk("bus_data", 96'(writedata_o), 96'(b.d));
        chk("bus_gap", 96'(cyc - last_bus), 96'(b.gap));
      end
      last_bus = cyc;
    end else begin
      chk("bus_idle", 96'({address_o, writedata_o}), 96'h0);
    end
    if (done_o) begin
      if (dq.size() == 0) begin
        chk("extra_done", 96'(done_o), 96'h0);
      end else begin
        d = dq.pop_front();
        chk("done_err", 96'(error_o), 96'(d.err));
        chk("done_polls", 96'(poll_cnt_o), 96'(d.pc));
        chk("done_result", result_o, d.res);
        chk("done_busy", 96'(busy_o), 96'h0);
        chk("done_lat", 96'(cyc - last_bus), 96'(d.gap));
      end
    end
  end

  // Configure the slave and push the expected bus/done traffic of one run.
  task automatic plan(input logic [95:0] p, input int npoll,
                      input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [3:0] drop);
    logic [95:0] res;
    bit          err;
    fin_at = poll_num + npoll;
    sres[0] = r0;
    sres[1] = r1;
    sres[2] = r2;
    drop_a = drop;
    for (int i = 0; i < 3; i++)
      bq.push_back('{1'b1, 4'(1 + i), p[32*i +: 32], 1});
    bq.push_back('{1'b1, 4'd0, 32'h1, 1});
    for (int k = 0; k < npoll; k++)
      bq.push_back('{1'b0, 4'd4, 32'h0, (k == 0) ? 1 : 6});
    for (int j = 0; j < 3; j++)
      bq.push_back('{1'b0, 4'(5 + j), 32'h0, 2});
    err = (drop == 4'd7);
    res = err ? {32'h0, r1, r0} : {r2, r1, r0};
    dq.push_back('{err, 16'(npoll), res, err ? 16 : 2});
  endtask

  task automatic start_run(input logic [95:0] p);
    @(posedge clk_sys_i); #1;
    param_i = p;
    run_i = 1'b1;
    mark_req++;
    @(posedge clk_sys_i); #1;
    run_i = 1'b0;
    param_i = ~p;
    chk("busy_start", 96'(busy_o), 96'h1);
    chk("err_clear", 96'(error_o), 96'h0);
    chk("poll_clear", 96'(poll_cnt_o), 96'h0);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk_sys_i); #1;
      if (bq.size() == 0 && dq.size() == 0) break;
    end
    chk("seq_pending", 96'(bq.size() + dq.size()), 96'h0);
    repeat (8) @(posedge clk_sys_i);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 96'(busy_o), 96'h0);
    chk({tag, "_done"}, 96'(done_o), 96'h0);
    chk({tag, "_err"}, 96'(error_o), 96'h0);
    chk({tag, "_polls"}, 96'(poll_cnt_o), 96'h0);
    chk({tag, "_res"}, result_o, 96'h0);
    chk({tag, "_bus"}, 96'({read_o, write_o, address_o, writedata_o}), 96'h0);
  endtask

  initial begin
    logic [95:0] p;
    bit          found;
    rst_sys_i = 1'b0;
    run_i = 1'b0;
    param_i = '0;
    repeat (3) @(posedge clk_sys_i);
    #1;
    chk_zero("reset");
    rst_sys_i = 1'b1;
    repeat (2) @(posedge clk_sys_i);

    // three polls before the slave reports finished
    p = {32'h3, 32'h2, 32'h1};
    plan(p, 3, 32'h11, 32'h22, 32'h33, 4'hF);
    start_run(p);
    wait_done(300);

    // immediate finish, known result words
    p = {$urandom, $urandom, $urandom};
    plan(p, 1, 32'hA5, 32'h5A, 32'hFF, 4'hF);
    start_run(p);
    wait_done(300);
    chk("res_hold", result_o, {32'hFF, 32'h5A, 32'hA5});

    // third result read never answered
    p = {$urandom, $urandom, $urandom};
    plan(p, 1, 32'hDEAD0001, 32'hBEEF0002, 32'hC0DE0003, 4'd7);
    start_run(p);
    wait_done(300);
    chk("err_sticky", 96'(error_o), 96'h1);

    // run_i while busy and stray readdatavalid during parameter writes
    p = {$urandom, $urandom, $urandom};
    plan(p, 2, 32'h1234, 32'h5678, 32'h9ABC, 4'hF);
    start_run(p);
    run_i = 1'b1;
    stray_req++;
    @(posedge clk_sys_i); #1;
    run_i = 1'b0;
    wait_done(300);

    // reset during the poll gap, then a fresh run
    p = {32'hCAFE, 32'hBEEF, 32'hF00D};
    fin_at = poll_num + 1000;
    drop_a = 4'hF;
    for (int i = 0; i < 3; i++)
      bq.push_back('{1'b1, 4'(1 + i), p[32*i +: 32], 1});
    bq.push_back('{1'b1, 4'd0, 32'h1, 1});
    bq.push_back('{1'b0, 4'd4, 32'h0, 1});
    start_run(p);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (read_o && address_o == 4'd4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk_sys_i); #1;
    end
    chk("poll_seen", 96'(found), 96'h1);
    repeat (2) @(posedge clk_sys_i);
    #1;
    chk("gap_polls", 96'(poll_cnt_o), 96'h1);
    rst_sys_i = 1'b0;
    @(posedge clk_sys_i); #1;
    rst_sys_i = 1'b1;
    chk_zero("midrst");
    repeat (12) @(posedge clk_sys_i);
    #1;
    chk("midrst_q", 96'(bq.size()), 96'h0);
    p = {$urandom, $urandom, $urandom};
    plan(p, 1, 32'h77, 32'h88, 32'h99, 4'hF);
    start_run(p);
    wait_done(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
